// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-style control path: opcodes, FSM states,
// ALU operation codes, datapath mux selects and the opcode class record.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b001100;
  localparam logic [5:0] OP_SW    = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b011000;
  localparam logic [5:0] OP_J     = 6'b010100;
  localparam logic [5:0] OP_JAL   = 6'b010110;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_AND   = 4'd1,
    ALU_OR    = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_FUNCT = 4'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_JUMP = 2'b01
  } pc_src_t;

  typedef enum logic [1:0] {
    RD_RT = 2'b00,
    RD_RD = 2'b01,
    RD_RA = 2'b10
  } reg_dst_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_t;

  typedef struct packed {
    logic is_r;
    logic is_alu_i;
    logic is_load;
    logic is_store;
    logic is_jump;
    logic is_link;
    logic is_halt;
    logic is_illegal;
  } op_class_t;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode -> instruction class map. The halt opcode takes priority over
// every other encoding; anything unrecognised is flagged illegal.
module opcode_classifier
  import cpu_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input  logic [5:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    // NOTE: default everything first so no branch can leave a field unassigned and infer a latch.
    cls = '0;
    if (opcode == HALT_OPCODE) begin
      cls.is_halt = 1'b1;
    end else begin
      case (opcode)
        OP_RTYPE:                                    cls.is_r       = 1'b1;
        OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: cls.is_alu_i   = 1'b1;
        OP_LW:                                       cls.is_load    = 1'b1;
        OP_SW:                                       cls.is_store   = 1'b1;
        OP_J:                                        cls.is_jump    = 1'b1;
        OP_JAL: begin
          cls.is_jump = 1'b1;
          cls.is_link = 1'b1;
        end
        default:                                     cls.is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller; outputs decode (state, op_q, mem_ready).
// Optional performance counters are built only when CTRL_PERF_CNT_EN is defined.
module multicycle_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic             alu_src_imm,
  output logic [3:0]       alu_op,
  output logic [2:0]       state_o,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t     state;
  logic [5:0] op_q;
  logic [5:0] fn_q;
  logic [5:0] cls_op;
  op_class_t  cls;
  logic       fn_q_unused;

  // The R-type function code is consumed by the ALU decoder, not by this controller.
  assign fn_q_unused = ^fn_q;

  // In DECODE the live opcode is classified; afterwards the latched one drives the datapath.
  assign cls_op = (state == DECODE) ? opcode : op_q;

  opcode_classifier #(.HALT_OPCODE(HALT_OPCODE)) u_classifier (
    .opcode (cls_op),
    .cls    (cls)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
      fn_q  <= '0;
    end else begin
      case (state)
        IDLE:   state <= FETCH;
        FETCH:  if (mem_ready) state <= DECODE;
        DECODE: begin
          op_q <= opcode;
          fn_q <= funct;
          if (cls.is_halt)         state <= HALT;
          else if (cls.is_illegal) state <= FETCH;
          else                     state <= EXEC;
        end
        EXEC: begin
          if (cls.is_jump)                      state <= FETCH;
          else if (cls.is_load || cls.is_store) state <= MEM;
          else                                  state <= WB;
        end
        MEM:    if (mem_ready) state <= cls.is_store ? FETCH : WB;
        WB:     state <= FETCH;
        HALT:   state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  assign state_o = state;

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_SEQ;
    reg_we       = 1'b0;
    reg_dst      = RD_RT;
    wb_sel       = WB_ALU;
    alu_src_imm  = 1'b0;
    alu_op       = ALU_ADD;
    halted       = 1'b0;
    illegal_op   = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        pc_we   = mem_ready;
      end
      DECODE: illegal_op = cls.is_illegal;
      EXEC, MEM, WB: begin
        // Selects stay stable from EXEC to the end of the instruction.
        alu_src_imm = cls.is_alu_i | cls.is_load | cls.is_store;
        if (cls.is_r)              alu_op = ALU_FUNCT;
        else if (op_q == OP_ANDI)  alu_op = ALU_AND;
        else if (op_q == OP_ORI)   alu_op = ALU_OR;
        else if (op_q == OP_SLTI)  alu_op = ALU_SLT;
        else                       alu_op = ALU_ADD;
        if (cls.is_r)              reg_dst = RD_RD;
        else if (cls.is_link)      reg_dst = RD_RA;
        if (cls.is_load)           wb_sel = WB_MEM;
        else if (cls.is_link)      wb_sel = WB_PC4;
        if (state == EXEC && cls.is_jump) begin
          pc_we  = 1'b1;
          pc_src = PC_JUMP;
          reg_we = cls.is_link;
        end
        if (state == MEM) begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = cls.is_store;
        end
        if (state == WB) reg_we = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic retire;

  // Last cycle of a completed instruction; illegal NOPs and the halt itself never retire.
  assign retire = (state == WB)
               || (state == EXEC && cls.is_jump)
               || (state == MEM && mem_ready && cls.is_store);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != HALT) cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (retire)        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`else
  assign cyc_cnt   = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle expectations are queued as each
// instruction is scripted, then popped and compared while the FSM executes it.
module tb_multicycle_ctrl_fsm;
  import cpu_ctrl_pkg::*;

  localparam int CNT_W = 32;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       we;
    logic       asel;
    logic       ir;
    logic       pcw;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] rd;
    logic [1:0] wb;
    logic       imm;
    logic [3:0] alu;
    logic       hlt;
    logic       ill;
  } obs_t;

  typedef struct packed {
    logic [5:0] op;
    logic       rdy;
    logic       ret;
    obs_t       exp;
  } step_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       opcode = '0;
  logic [5:0]       funct = 6'h20;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we;
  logic [1:0]       pc_src, reg_dst, wb_sel;
  logic             alu_src_imm, halted, illegal_op;
  logic [3:0]       alu_op;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] cyc_cnt, instr_cnt;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.CNT_W(CNT_W), .HALT_OPCODE(6'b111111)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .funct        (funct),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .reg_we       (reg_we),
    .reg_dst      (reg_dst),
    .wb_sel       (wb_sel),
    .alu_src_imm  (alu_src_imm),
    .alu_op       (alu_op),
    .state_o      (state_o),
    .halted       (halted),
    .illegal_op   (illegal_op),
    .cyc_cnt      (cyc_cnt),
    .instr_cnt    (instr_cnt)
  );

  obs_t obs;
  always_comb begin
    obs      = '0;
    obs.st   = state_o;
    obs.req  = mem_req;
    obs.we   = mem_we;
    obs.asel = mem_addr_sel;
    obs.ir   = ir_we;
    obs.pcw  = pc_we;
    obs.pcs  = pc_src;
    obs.rw   = reg_we;
    obs.rd   = reg_dst;
    obs.wb   = wb_sel;
    obs.imm  = alu_src_imm;
    obs.alu  = alu_op;
    obs.hlt  = halted;
    obs.ill  = illegal_op;
  end

  step_t            q[$];
  string            tags[$];
  int               n_checks = 0;
  int               n_pass = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] exp_cyc = '0;
  logic [CNT_W-1:0] exp_instr = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  function automatic obs_t mk(input state_t s);
    obs_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  task automatic push(input string tag, input logic [5:0] op, input logic rdy,
                      input logic ret, input obs_t e);
    step_t s;
    s.op  = op;
    s.rdy = rdy;
    s.ret = ret;
    s.exp = e;
    q.push_back(s);
    tags.push_back(tag);
  endtask

  task automatic push_fetch(input string tag, input logic [5:0] op, input int waits);
    obs_t e;
    e = mk(FETCH);
    e.req = 1'b1;
    for (int i = 0; i < waits; i++) push({tag, "/fetch_wait"}, op, 1'b0, 1'b0, e);
    e.ir  = 1'b1;
    e.pcw = 1'b1;
    push({tag, "/fetch"}, op, 1'b1, 1'b0, e);
  endtask

  task automatic push_decode(input string tag, input logic [5:0] op, input logic ill);
    obs_t e;
    e = mk(DECODE);
    e.ill = ill;
    push({tag, "/decode"}, op, 1'b0, 1'b0, e);
  endtask

  task automatic push_alu(input string tag, input logic [5:0] op, input logic imm,
                          input alu_op_t alu, input reg_dst_t rd);
    obs_t e;
    push_fetch(tag, op, 0);
    push_decode(tag, op, 1'b0);
    e = mk(EXEC);
    e.imm = imm;
    e.alu = alu;
    e.rd  = rd;
    push({tag, "/exec"}, op, 1'b1, 1'b0, e);
    e.st = WB;
    e.rw = 1'b1;
    push({tag, "/wb"}, op, 1'b1, 1'b1, e);
  endtask

  task automatic push_mem(input string tag, input logic [5:0] op, input logic store,
                          input int fetch_waits, input int mem_waits);
    obs_t e;
    push_fetch(tag, op, fetch_waits);
    push_decode(tag, op, 1'b0);
    e = mk(EXEC);
    e.imm = 1'b1;
    e.alu = ALU_ADD;
    e.wb  = store ? WB_ALU : WB_MEM;
    push({tag, "/exec"}, op, 1'b1, 1'b0, e);
    e.st   = MEM;
    e.req  = 1'b1;
    e.asel = 1'b1;
    e.we   = store;
    for (int i = 0; i < mem_waits; i++) push({tag, "/mem_wait"}, op, 1'b0, 1'b0, e);
    push({tag, "/mem"}, op, 1'b1, store, e);
    if (!store) begin
      e = mk(WB);
      e.imm = 1'b1;
      e.wb  = WB_MEM;
      e.rw  = 1'b1;
      push({tag, "/wb"}, op, 1'b1, 1'b1, e);
    end
  endtask

  task automatic push_jump(input string tag, input logic [5:0] op, input logic link);
    obs_t e;
    push_fetch(tag, op, 0);
    push_decode(tag, op, 1'b0);
    e = mk(EXEC);
    e.pcw = 1'b1;
    e.pcs = PC_JUMP;
    if (link) begin
      e.rw = 1'b1;
      e.rd = RD_RA;
      e.wb = WB_PC4;
    end
    push({tag, "/exec"}, op, 1'b1, 1'b1, e);
  endtask

  // Only DECODE sees the real opcode; other cycles carry a scrambled value so the
  // datapath controls must come from the latched copy.
  task automatic run_queue;
    step_t s;
    string t;
    while (q.size() > 0) begin
      s = q.pop_front();
      t = tags.pop_front();
      @(negedge clk);
      opcode    = (s.exp.st == DECODE) ? s.op : (s.op ^ 6'b101010);
      mem_ready = s.rdy;
      #1;
      check(t, 64'(obs), 64'(s.exp));
      check({t, "/cyc_cnt"}, 64'(cyc_cnt), PERF ? 64'(exp_cyc) : 64'd0);
      check({t, "/instr_cnt"}, 64'(instr_cnt), PERF ? 64'(exp_instr) : 64'd0);
      if (s.exp.st != HALT) exp_cyc++;
      if (s.ret) exp_instr++;
    end
  endtask

  initial begin
    obs_t e;
    #1;
    check("reset/outputs", 64'(obs), 64'(mk(IDLE)));
    check("reset/cyc_cnt", 64'(cyc_cnt), 64'd0);
    check("reset/instr_cnt", 64'(instr_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    push("start/idle", 6'd0, 1'b0, 1'b0, mk(IDLE));
    push_alu("addi", OP_ADDI, 1'b1, ALU_ADD, RD_RT);
    push_alu("rtype", OP_RTYPE, 1'b0, ALU_FUNCT, RD_RD);
    push_alu("andi", OP_ANDI, 1'b1, ALU_AND, RD_RT);
    push_alu("ori", OP_ORI, 1'b1, ALU_OR, RD_RT);
    push_alu("slti", OP_SLTI, 1'b1, ALU_SLT, RD_RT);
    push_mem("lw", OP_LW, 1'b0, 1, 3);
    push_mem("sw", OP_SW, 1'b1, 0, 0);
    push_jump("j", OP_J, 1'b0);
    push_jump("jal", OP_JAL, 1'b1);
    push_fetch("illegal", 6'b110011, 0);
    push_decode("illegal", 6'b110011, 1'b1);
    push_alu("addiu", OP_ADDIU, 1'b1, ALU_ADD, RD_RT);
    e = mk(FETCH);
    e.req = 1'b1;
    push("rst_mid/fetch_wait", OP_ADDI, 1'b0, 1'b0, e);
    push("rst_mid/fetch_wait", OP_ADDI, 1'b0, 1'b0, e);
    run_queue();

    // Reset asserted while FETCH is waiting on memory, with mem_ready arriving at once.
    #2;
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rst_mid/mem_req", 64'(mem_req), 64'd0);
    check("rst_mid/state", 64'(state_o), 64'(IDLE));
    check("rst_mid/outputs", 64'(obs), 64'(mk(IDLE)));
    check("rst_mid/cyc_cnt", 64'(cyc_cnt), 64'd0);
    exp_cyc   = '0;
    exp_instr = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    push("rst_mid/idle", 6'd0, 1'b0, 1'b0, mk(IDLE));
    push_fetch("halt", 6'b111111, 0);
    push_decode("halt", 6'b111111, 1'b0);
    e = mk(HALT);
    e.hlt = 1'b1;
    for (int i = 0; i < 20; i++) push("halt/stopped", 6'b111111, 1'(i % 2), 1'b0, e);
    run_queue();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
